// File: rtl/tailmon_pkg.sv
// Shared types and lamp-pattern constants for the tail-light protocol monitor.
// Lamp vectors are packed as {lc, lb, la, ra, rb, rc}. In both halves the
// inner lamp lights first, so a turn frame is a prefix filled from the inside.
package tailmon_pkg;

    // Decoded operating mode reported on the mode output.
    typedef enum logic [2:0] {
        ModeIdle    = 3'd0,
        ModeLeft    = 3'd1,
        ModeRight   = 3'd2,
        ModeBrake   = 3'd3,
        ModeAlarm   = 3'd4,
        ModeUnknown = 3'd7
    } mode_e;

    // Classification of one clock's lamp frame.
    typedef enum logic [3:0] {
        FrameOff,
        FrameL1,
        FrameL2,
        FrameL3,
        FrameR1,
        FrameR2,
        FrameR3,
        FrameAll,
        FrameBad
    } frame_e;

    // Legal lamp patterns. Anything else classifies as FrameBad.
    localparam logic [5:0] LampOff = 6'b000_000;
    localparam logic [5:0] LampL1  = 6'b001_000;
    localparam logic [5:0] LampL2  = 6'b011_000;
    localparam logic [5:0] LampL3  = 6'b111_000;
    localparam logic [5:0] LampR1  = 6'b000_100;
    localparam logic [5:0] LampR2  = 6'b000_110;
    localparam logic [5:0] LampR3  = 6'b000_111;
    localparam logic [5:0] LampAll = 6'b111_111;

    // Protocol tracker states.
    // Gap states sit between two turn sequences; StAll1/StAoff resolve whether
    // a run of full-on frames is a brake (steady) or an alarm (flashing).
    typedef enum logic [3:0] {
        StIdle,
        StL1,
        StL2,
        StL3,
        StLgap,
        StR1,
        StR2,
        StR3,
        StRgap,
        StAll1,
        StAoff,
        StBrake,
        StAlon,
        StAloff
    } state_e;

endpackage

// File: rtl/tail_frame_classify.sv
// Purely combinational classifier: maps the six lamp levels onto a frame class.
module tail_frame_classify
    import tailmon_pkg::*;
(
    input  logic   la,
    input  logic   lb,
    input  logic   lc,
    input  logic   ra,
    input  logic   rb,
    input  logic   rc,
    output frame_e frame
);

    logic [5:0] lamps;

    assign lamps = {lc, lb, la, ra, rb, rc};

    // Exact-match decode; mixed sides and non-prefix patterns fall to FrameBad.
    always_comb begin
        frame = FrameBad;
        case (lamps)
            LampOff: frame = FrameOff;
            LampL1:  frame = FrameL1;
            LampL2:  frame = FrameL2;
            LampL3:  frame = FrameL3;
            LampR1:  frame = FrameR1;
            LampR2:  frame = FrameR2;
            LampR3:  frame = FrameR3;
            LampAll: frame = FrameAll;
            default: frame = FrameBad;
        endcase
    end

endmodule

// File: rtl/taillight_monitor.sv
// Passive protocol monitor for the tail-light sequencer lamp outputs.
// Tracks each frame against the legal sequence, reports the decoded mode,
// pulses seq_done on completed turn sequences and err on violations, and
// keeps a saturating violation count. All outputs are registered (1 cycle).
// Optional build macro TAILMON_SEQCNT_EN adds per-side wrapping counters of
// completed turn sequences (seq_cnt_l, seq_cnt_r).
module taillight_monitor
    import tailmon_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             la,
    input  logic             lb,
    input  logic             lc,
    input  logic             ra,
    input  logic             rb,
    input  logic             rc,
    output logic [2:0]       mode,
    output logic             seq_done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
`ifdef TAILMON_SEQCNT_EN
    ,
    output logic [CNT_W-1:0] seq_cnt_l,
    output logic [CNT_W-1:0] seq_cnt_r
`endif
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    frame_e frame;
    state_e state_q, state_d;
    mode_e  mode_q, mode_d;
    logic   done_l, done_r;
    logic   viol;

    tail_frame_classify u_classify (
        .la    (la),
        .lb    (lb),
        .lc    (lc),
        .ra    (ra),
        .rb    (rb),
        .rc    (rc),
        .frame (frame)
    );

    assign mode = mode_q;

    // Transition table: next state, next mode, completion and violation flags.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        done_l  = 1'b0;
        done_r  = 1'b0;
        viol    = 1'b0;
        unique case (state_q)
            StIdle: begin
                case (frame)
                    FrameOff: begin
                        state_d = StIdle;
                        mode_d  = ModeIdle;
                    end
                    FrameL1: begin
                        state_d = StL1;
                        mode_d  = ModeLeft;
                    end
                    FrameR1: begin
                        state_d = StR1;
                        mode_d  = ModeRight;
                    end
                    // Mode is held until the next frame tells brake from alarm.
                    FrameAll: state_d = StAll1;
                    default:  viol = 1'b1;
                endcase
            end
            StL1: begin
                if (frame == FrameL2) state_d = StL2;
                else                  viol = 1'b1;
            end
            StL2: begin
                if (frame == FrameL3) state_d = StL3;
                else                  viol = 1'b1;
            end
            StL3: begin
                if (frame == FrameOff) begin
                    state_d = StLgap;
                    done_l  = 1'b1;
                end else begin
                    viol = 1'b1;
                end
            end
            StLgap: begin
                case (frame)
                    FrameL1: begin
                        state_d = StL1;
                        mode_d  = ModeLeft;
                    end
                    FrameOff: begin
                        state_d = StIdle;
                        mode_d  = ModeIdle;
                    end
                    default: viol = 1'b1;
                endcase
            end
            StR1: begin
                if (frame == FrameR2) state_d = StR2;
                else                  viol = 1'b1;
            end
            StR2: begin
                if (frame == FrameR3) state_d = StR3;
                else                  viol = 1'b1;
            end
            StR3: begin
                if (frame == FrameOff) begin
                    state_d = StRgap;
                    done_r  = 1'b1;
                end else begin
                    viol = 1'b1;
                end
            end
            StRgap: begin
                case (frame)
                    FrameR1: begin
                        state_d = StR1;
                        mode_d  = ModeRight;
                    end
                    FrameOff: begin
                        state_d = StIdle;
                        mode_d  = ModeIdle;
                    end
                    default: viol = 1'b1;
                endcase
            end
            StAll1: begin
                case (frame)
                    FrameAll: begin
                        state_d = StBrake;
                        mode_d  = ModeBrake;
                    end
                    FrameOff: state_d = StAoff;
                    default:  viol = 1'b1;
                endcase
            end
            StAoff: begin
                // A lone flash followed by OFF is tolerated and just ends.
                case (frame)
                    FrameAll: begin
                        state_d = StAlon;
                        mode_d  = ModeAlarm;
                    end
                    FrameOff: begin
                        state_d = StIdle;
                        mode_d  = ModeIdle;
                    end
                    default: viol = 1'b1;
                endcase
            end
            StBrake: begin
                case (frame)
                    FrameAll: state_d = StBrake;
                    FrameOff: begin
                        state_d = StIdle;
                        mode_d  = ModeIdle;
                    end
                    default: viol = 1'b1;
                endcase
            end
            StAlon: begin
                if (frame == FrameOff) state_d = StAloff;
                else                   viol = 1'b1;
            end
            StAloff: begin
                case (frame)
                    FrameAll: state_d = StAlon;
                    FrameOff: begin
                        state_d = StIdle;
                        mode_d  = ModeIdle;
                    end
                    default: viol = 1'b1;
                endcase
            end
            default: viol = 1'b1;
        endcase

        // The violating frame is consumed; the next frame is judged from idle.
        if (viol) begin
            state_d = StIdle;
            mode_d  = ModeUnknown;
        end
    end

    // State, registered outputs and counters; reset dominates everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            mode_q    <= ModeIdle;
            seq_done  <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
`ifdef TAILMON_SEQCNT_EN
            seq_cnt_l <= '0;
            seq_cnt_r <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            seq_done <= done_l | done_r;
            err      <= viol;
            if (viol && (err_cnt != CntMax)) begin
                err_cnt <= err_cnt + CntOne;
            end
`ifdef TAILMON_SEQCNT_EN
            // Wrapping counters, stepped alongside their side's seq_done pulse.
            if (done_l) seq_cnt_l <= seq_cnt_l + CntOne;
            if (done_r) seq_cnt_r <= seq_cnt_r + CntOne;
`endif
        end
    end

endmodule
